// File: rtl/sram_bist_pkg.sv
// Shared definitions for the March C- SRAM BIST: sequencer states and the
// per-element operation table (read/write values and address direction).
package sram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    M4,
    M5,
    DRAIN
  } bist_state_e;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  typedef struct packed {
    logic [2:0] idx;
    logic       has_rd;
    logic       rd_val;
    logic       has_wr;
    logic       wr_val;
    logic       down;
  } elem_t;

  function automatic logic elem_down(bist_state_e st);
    return (st == M3) || (st == M4);
  endfunction

  function automatic elem_t elem_info(bist_state_e st);
    elem_t e;
    e = '0;
    case (st)
      M0:      begin e.idx = ELEM_M0; e.has_wr = 1'b1; e.wr_val = 1'b0; end
      M1:      begin e.idx = ELEM_M1; e.has_rd = 1'b1; e.rd_val = 1'b0; e.has_wr = 1'b1; e.wr_val = 1'b1; end
      M2:      begin e.idx = ELEM_M2; e.has_rd = 1'b1; e.rd_val = 1'b1; e.has_wr = 1'b1; e.wr_val = 1'b0; end
      M3:      begin e.idx = ELEM_M3; e.has_rd = 1'b1; e.rd_val = 1'b0; e.has_wr = 1'b1; e.wr_val = 1'b1; end
      M4:      begin e.idx = ELEM_M4; e.has_rd = 1'b1; e.rd_val = 1'b1; e.has_wr = 1'b1; e.wr_val = 1'b0; end
      M5:      begin e.idx = ELEM_M5; e.has_rd = 1'b1; e.rd_val = 1'b0; end
      default: e = '0;
    endcase
    e.down = elem_down(st);
    return e;
  endfunction

  function automatic bist_state_e next_elem(bist_state_e st);
    case (st)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      M4:      return M5;
      M5:      return DRAIN;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// BIST address counter: loads the first address of an element (0 or max),
// steps up or down, and flags the element's last address.
module sram_bist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_i,
  input  logic              init_down_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_o <= '0;
    end else if (init_i) begin
      addr_o <= init_down_i ? '1 : '0;
    end else if (step_i) begin
      addr_o <= down_i ? addr_o - ADDR_W'(1) : addr_o + ADDR_W'(1);
    end
  end

  assign last_o = down_i ? (addr_o == '0) : (addr_o == '1);

endmodule

// File: rtl/sram_march_bist.sv
// SRAM wrapper with a March C- self-test sequencer; functional accesses pass
// straight to the macro while idle, BIST owns the port for the whole run.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] bm_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              bist_start_i,
  output logic              bist_busy_o,
  output logic              bist_done_o,
  output logic              bist_pass_o,
  output logic [ADDR_W-1:0] bist_fail_addr_o,
  output logic [2:0]        bist_fail_elem_o,
  output logic              sram_men_o,
  output logic              sram_wen_o,
  output logic              sram_ren_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_din_o,
  output logic [DATA_W-1:0] sram_bm_o,
  input  logic [DATA_W-1:0] sram_dout_i
);

  bist_state_e       state_q, state_d, nxt_elem;
  logic              phase_q, phase_d;
  elem_t             cur;
  logic              bist_act, op_rd, final_op, start;
  logic              ag_init, ag_init_down, ag_step, ag_last;
  logic [ADDR_W-1:0] ag_addr;

  logic              vld_p1;
  logic [DATA_W-1:0] exp_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [2:0]        elem_p1;
  logic              miscmp;

  logic              rvalid_q, done_q, pass_q, fail_seen_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;

  sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .init_i      (ag_init),
    .init_down_i (ag_init_down),
    .step_i      (ag_step),
    .down_i      (cur.down),
    .addr_o      (ag_addr),
    .last_o      (ag_last)
  );

  // Two-op elements read in phase 0 and write the same address in phase 1.
  always_comb begin
    cur      = elem_info(state_q);
    nxt_elem = next_elem(state_q);
    bist_act = (state_q != IDLE) && (state_q != DRAIN);
    op_rd    = cur.has_rd && !phase_q;
    final_op = !(cur.has_rd && cur.has_wr) || phase_q;
    start    = (state_q == IDLE) && bist_start_i;
    gnt_o    = (state_q == IDLE) && req_i && !bist_start_i && rst_ni;
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    ag_init      = 1'b0;
    ag_init_down = 1'b0;
    ag_step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bist_start_i) begin
          state_d = M0;
          phase_d = 1'b0;
          ag_init = 1'b1;
        end
      end
      DRAIN: state_d = IDLE;
      default: begin
        phase_d = cur.has_rd && cur.has_wr && !phase_q;
        if (final_op) begin
          if (ag_last) begin
            state_d      = nxt_elem;
            ag_init      = 1'b1;
            ag_init_down = elem_down(nxt_elem);
          end else begin
            ag_step = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    sram_men_o  = 1'b0;
    sram_wen_o  = 1'b0;
    sram_ren_o  = 1'b0;
    sram_addr_o = '0;
    sram_din_o  = '0;
    sram_bm_o   = '0;
    if (bist_act) begin
      sram_men_o  = 1'b1;
      sram_wen_o  = !op_rd;
      sram_ren_o  = op_rd;
      sram_addr_o = ag_addr;
      sram_din_o  = {DATA_W{cur.wr_val}};
      sram_bm_o   = '1;
    end else if (gnt_o) begin
      sram_men_o  = 1'b1;
      sram_wen_o  = we_i;
      sram_ren_o  = !we_i;
      sram_addr_o = addr_i;
      sram_din_o  = wdata_i;
      sram_bm_o   = bm_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // ---- p1: macro read data returns; compare against the registered expectation
  always_ff @(posedge clk_i) begin
    exp_p1  <= {DATA_W{cur.rd_val}};
    addr_p1 <= ag_addr;
    elem_p1 <= cur.idx;
  end

  assign miscmp = vld_p1 && (sram_dout_i != exp_p1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_p1      <= 1'b0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_seen_q <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      vld_p1   <= bist_act && op_rd;
      rvalid_q <= gnt_o && !we_i;
      done_q   <= (state_q == DRAIN);
      if (start) begin
        pass_q      <= 1'b0;
        fail_seen_q <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= '0;
      end else begin
        if (miscmp && !fail_seen_q) begin
          fail_seen_q <= 1'b1;
          fail_addr_q <= addr_p1;
          fail_elem_q <= elem_p1;
        end
        if (state_q == DRAIN) pass_q <= !(fail_seen_q || miscmp);
      end
    end
  end

  assign rvalid_o         = rvalid_q;
  assign rdata_o          = rvalid_q ? sram_dout_i : '0;
  assign bist_busy_o      = (state_q != IDLE);
  assign bist_done_o      = done_q;
  assign bist_pass_o      = pass_q;
  assign bist_fail_addr_o = fail_addr_q;
  assign bist_fail_elem_o = fail_elem_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist: behavioural macro with injectable
// stuck-at bits, a loop-level March C- reference model, and a second small instance.
module tb_sram_march_bist;

  localparam int DW = 64, AW = 8, DEPTH = 256;
  localparam int DWS = 32, AWS = 4, DEPTHS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req, we, start;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, bm;
  logic          gnt, rvalid, busy, done, pass;
  logic [DW-1:0] rdata;
  logic [AW-1:0] faddr;
  logic [2:0]    felem;
  logic          men, wen, ren;
  logic [AW-1:0] saddr;
  logic [DW-1:0] sdin, sbm, sdout;

  logic           req_s, we_s, start_s;
  logic [AWS-1:0] addr_s;
  logic [DWS-1:0] wdata_s, bm_s;
  logic           gnt_s, rvalid_s, busy_s, done_s, pass_s;
  logic [DWS-1:0] rdata_s;
  logic [AWS-1:0] faddr_s;
  logic [2:0]     felem_s;
  logic           men_s, wen_s, ren_s;
  logic [AWS-1:0] saddr_s;
  logic [DWS-1:0] sdin_s, sbm_s, sdout_s;

  sram_march_bist #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .bm_i(bm), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .bist_start_i(start), .bist_busy_o(busy), .bist_done_o(done), .bist_pass_o(pass),
    .bist_fail_addr_o(faddr), .bist_fail_elem_o(felem),
    .sram_men_o(men), .sram_wen_o(wen), .sram_ren_o(ren), .sram_addr_o(saddr),
    .sram_din_o(sdin), .sram_bm_o(sbm), .sram_dout_i(sdout)
  );

  sram_march_bist #(.DATA_W(DWS), .ADDR_W(AWS)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_s), .we_i(we_s), .addr_i(addr_s),
    .wdata_i(wdata_s), .bm_i(bm_s), .gnt_o(gnt_s), .rvalid_o(rvalid_s), .rdata_o(rdata_s),
    .bist_start_i(start_s), .bist_busy_o(busy_s), .bist_done_o(done_s), .bist_pass_o(pass_s),
    .bist_fail_addr_o(faddr_s), .bist_fail_elem_o(felem_s),
    .sram_men_o(men_s), .sram_wen_o(wen_s), .sram_ren_o(ren_s), .sram_addr_o(saddr_s),
    .sram_din_o(sdin_s), .sram_bm_o(sbm_s), .sram_dout_i(sdout_s)
  );

  // Macro models: one-cycle read latency, stuck-at faults applied on read.
  logic [DW-1:0]  mem [DEPTH];
  logic [DW-1:0]  sa0 [DEPTH];
  logic [DW-1:0]  sa1 [DEPTH];
  logic [DWS-1:0] mem_s [DEPTHS];

  always @(posedge clk) begin
    if (men) begin
      if (wen) mem[saddr] <= (mem[saddr] & ~sbm) | (sdin & sbm);
      if (ren) sdout <= (mem[saddr] & ~sa0[saddr]) | sa1[saddr];
    end
    if (men_s) begin
      if (wen_s) mem_s[saddr_s] <= (mem_s[saddr_s] & ~sbm_s) | (sdin_s & sbm_s);
      if (ren_s) sdout_s <= mem_s[saddr_s];
    end
  end

  typedef struct {
    logic          pass;
    logic [AW-1:0] addr;
    logic [2:0]    elem;
    int            len;
  } bist_exp_t;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] rd_q [$];
  bist_exp_t     bist_q [$];
  int            len_s_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
    end
  endtask

  task automatic flag_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  // Reference March C-: element list straight from the algorithm definition.
  function automatic void march_model(output bist_exp_t r);
    int rdv [6] = '{-1, 0, 1, 0, 1, 0};
    int wrv [6] = '{0, 1, 0, 1, 0, -1};
    bit dn  [6] = '{0, 0, 0, 1, 1, 0};
    logic [DW-1:0] v, ev;
    int a;
    r.pass = 1'b1;
    r.addr = '0;
    r.elem = '0;
    r.len  = 10 * DEPTH + 1;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        a = dn[e] ? DEPTH - 1 - k : k;
        if (rdv[e] >= 0) begin
          v  = (ref_mem[a] & ~sa0[a]) | sa1[a];
          ev = (rdv[e] == 1) ? '1 : '0;
          if (v !== ev && r.pass) begin
            r.pass = 1'b0;
            r.addr = AW'(a);
            r.elem = 3'(e);
          end
        end
        if (wrv[e] >= 0) ref_mem[a] = (wrv[e] == 1) ? '1 : '0;
      end
    end
  endfunction

  int busy_cnt = 0;
  int busy_cnt_s = 0;

  always @(negedge clk) begin : monitor
    logic [DW-1:0] ed;
    bist_exp_t     eb;
    int            el;
    if (rvalid) begin
      if (rd_q.size() == 0) flag_fail("rvalid_unexpected");
      else begin
        ed = rd_q.pop_front();
        check("rdata", rdata, ed);
      end
    end
    if (done) begin
      if (bist_q.size() == 0) flag_fail("done_unexpected");
      else begin
        eb = bist_q.pop_front();
        check("bist_pass", 64'(pass), 64'(eb.pass));
        check("fail_addr", 64'(faddr), 64'(eb.addr));
        check("fail_elem", 64'(felem), 64'(eb.elem));
        check("busy_len", 64'(busy_cnt), 64'(eb.len));
      end
    end
    if (busy) busy_cnt++; else busy_cnt = 0;
    if (rvalid_s) flag_fail("rvalid_s_unexpected");
    if (done_s) begin
      if (len_s_q.size() == 0) flag_fail("done_s_unexpected");
      else begin
        el = len_s_q.pop_front();
        check("small_pass", 64'(pass_s), 64'(1));
        check("small_busy_len", 64'(busy_cnt_s), 64'(el));
      end
    end
    if (busy_s) busy_cnt_s++; else busy_cnt_s = 0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic func_op(input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
    req = 1'b1; we = w; addr = a; wdata = d; bm = m;
    #1;
    check("gnt_idle", 64'(gnt), 64'(1));
    if (w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
    else   rd_q.push_back((ref_mem[a] & ~sa0[a]) | sa1[a]);
    tick(1);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic wait_bist_q();
    int n = 0;
    while (bist_q.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    if (bist_q.size() != 0) begin
      flag_fail("bist_timeout");
      bist_q.delete();
    end
  endtask

  // disturb: restart and functional requests mid-run; with_req: request in the start cycle
  task automatic run_bist(input bit disturb, input bit with_req);
    bist_exp_t r;
    march_model(r);
    bist_q.push_back(r);
    start = 1'b1;
    req = with_req;
    #1;
    check("gnt_start_collision", 64'(gnt), 64'(0));
    tick(1);
    start = 1'b0;
    req = 1'b0;
    check("busy_after_start", 64'(busy), 64'(1));
    check("pass_cleared", 64'(pass), 64'(0));
    if (disturb) begin
      tick(98);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
        req = 1'b1; we = i[0]; addr = AW'($urandom_range(0, DEPTH - 1));
        #1;
        check("gnt_during_run", 64'(gnt), 64'(0));
        tick(1);
      end
      req = 1'b0; we = 1'b0;
    end
    wait_bist_q();
    tick(2);
  endtask

  initial begin
    bist_exp_t dummy;
    int a, b;
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; start = 1'b0; addr = '0; wdata = '0; bm = '0;
    req_s = 1'b0; we_s = 1'b0; start_s = 1'b0; addr_s = '0; wdata_s = '0; bm_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sa0[i] = '0;
      sa1[i] = '0;
      ref_mem[i] = '0;
    end
    tick(3);
    req = 1'b1;
    #1;
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pass", 64'(pass), 64'(0));
    check("rst_fail_addr", 64'(faddr), 64'(0));
    check("rst_fail_elem", 64'(felem), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_men", 64'({men, wen, ren}), 64'(0));
    req = 1'b0;
    rst_n = 1'b1;
    tick(2);

    run_bist(1'b0, 1'b0);
    run_bist(1'b1, 1'b0);

    func_op(1'b1, 8'h10, '0, '1);
    func_op(1'b1, 8'h10, 64'hA5, 64'h0F);
    func_op(1'b0, 8'h10, '0, '0);
    tick(1);

    for (int i = 0; i < 80; i++) begin
      func_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
              {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) tick(1);
    end
    tick(3);

    sa0[5] = 64'h8;
    run_bist(1'b0, 1'b1);
    sa0[5] = '0;

    for (int t = 0; t < 3; t++) begin
      a = $urandom_range(0, DEPTH - 1);
      b = $urandom_range(0, DW - 1);
      if ($urandom_range(0, 1) == 1) sa1[a] = DW'(1) << b;
      else                           sa0[a] = DW'(1) << b;
      run_bist(1'b0, 1'b0);
      sa0[a] = '0;
      sa1[a] = '0;
    end

    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(699);
    rst_n = 1'b0;
    tick(1);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_men", 64'({men, wen, ren}), 64'(0));
    check("abort_fail_addr", 64'(faddr), 64'(0));
    rst_n = 1'b1;
    march_model(dummy);
    tick(40);
    run_bist(1'b0, 1'b0);

    len_s_q.push_back(10 * DEPTHS + 1);
    start_s = 1'b1;
    tick(1);
    start_s = 1'b0;
    for (int n = 0; n < 400 && len_s_q.size() != 0; n++) tick(1);
    if (len_s_q.size() != 0) begin
      flag_fail("small_timeout");
      len_s_q.delete();
    end
    tick(2);

    if (rd_q.size() != 0) flag_fail("rdata_missing");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
